sccb_bus_arbiter: RTL and testbench

//  Shares one I2C_Master (SCCB-capable) between NUM_REQ register-access clients: boot-time init sequencer,

---
 rtl/sccb_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sccb_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_bus_arbiter.sv
// sccb_bus_arbiter: round-robin sharing of one SCCB/I2C master between NUM_REQ register-access clients
module sccb_bus_arbiter #(
    parameter int                 NUM_REQ        = 3,
    parameter logic [NUM_REQ-1:0] SCCB_MASK      = '1,
    parameter logic [23:0]        TIMEOUT_CYCLES = 24'd2000000
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [2*NUM_REQ-1:0]    req_mode_i,
    input  logic [7*NUM_REQ-1:0]    req_slave_addr_i,
    input  logic [8*NUM_REQ-1:0]    req_reg_addr_i,
    input  logic [2*NUM_REQ-1:0]    req_burst_len_i,
    input  logic [32*NUM_REQ-1:0]   req_tx_data_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    output logic [NUM_REQ-1:0]      req_done_o,
    output logic [NUM_REQ-1:0]      req_timeout_o,
    output logic [31:0]             rd_data_o,
    output logic                    busy_o,
    output logic                    m_start_o,
    input  logic                    m_ready_i,
    input  logic                    m_done_i,
    output logic                    m_sccb_en_o,
    output logic [1:0]              m_mode_o,
    output logic [6:0]              m_slave_addr_o,
    output logic [7:0]              m_reg_addr_o,
    output logic [1:0]              m_burst_len_o,
    output logic [31:0]             m_tx_data_o,
    input  logic [31:0]             m_rx_data_i
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_ISSUE, S_WAIT, S_RELEASE} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] w_q, w_d, rr_q, rr_d, win;
    logic [IW:0] s;
    logic [23:0] wd_q, wd_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d, to_q, to_d;
    logic start_q, start_d, sccb_q, sccb_d;
    logic [31:0] rd_q, rd_d, tx_q, tx_d;
    logic [1:0] mode_q, mode_d, bl_q, bl_d;
    logic [6:0] sa_q, sa_d;
    logic [7:0] ra_q, ra_d;

    assign gnt_o          = gnt_q;
    assign req_done_o     = done_q;
    assign req_timeout_o  = to_q;
    assign rd_data_o      = rd_q;
    assign busy_o         = state_q != S_IDLE;
    assign m_start_o      = start_q;
    assign m_sccb_en_o    = sccb_q;
    assign m_mode_o       = mode_q;
    assign m_slave_addr_o = sa_q;
    assign m_reg_addr_o   = ra_q;
    assign m_burst_len_o  = bl_q;
    assign m_tx_data_o    = tx_q;

    // round-robin scan starting at rr_q; walking backwards lets the nearest requester win
    always_comb begin
        win = '0;
        s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = {1'b0, rr_q} + (IW+1)'(k);
            s = (s >= (IW+1)'(NUM_REQ)) ? s - (IW+1)'(NUM_REQ) : s;
            win = req_i[s[IW-1:0]] ? s[IW-1:0] : win;
        end
    end

    // transaction sequencing; outputs are registered to reflect the state being entered
    always_comb begin
        state_d = state_q;
        w_d = w_q;
        rr_d = rr_q;
        wd_d = wd_q;
        gnt_d = gnt_q;
        done_d = '0;
        to_d = '0;
        start_d = 1'b0;
        rd_d = rd_q;
        sccb_d = sccb_q;
        mode_d = mode_q;
        sa_d = sa_q;
        ra_d = ra_q;
        bl_d = bl_q;
        tx_d = tx_q;
        case (state_q)
            S_IDLE: if (|req_i) begin
                w_d = win;
                gnt_d = '0;
                gnt_d[win] = 1'b1;
                state_d = S_GRANT;
            end
            S_GRANT: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (w_q == IW'(i)) begin
                        sccb_d = SCCB_MASK[i];
                        mode_d = req_mode_i[2*i +: 2];
                        sa_d = req_slave_addr_i[7*i +: 7];
                        ra_d = req_reg_addr_i[8*i +: 8];
                        bl_d = req_burst_len_i[2*i +: 2];
                        tx_d = req_tx_data_i[32*i +: 32];
                    end
                end
                state_d = S_ISSUE;
            end
            S_ISSUE: if (m_ready_i) begin
                start_d = 1'b1;
                wd_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_done_i) begin
                    rd_d = m_rx_data_i;
                    done_d[w_q] = 1'b1;
                    gnt_d = '0;
                    state_d = S_RELEASE;
                end else if (wd_q == TIMEOUT_CYCLES - 24'd1) begin
                    to_d[w_q] = 1'b1;
                    gnt_d = '0;
                    state_d = S_RELEASE;
                end else begin
                    wd_d = wd_q + 24'd1;
                end
            end
            S_RELEASE: begin
                rr_d = (w_q == IW'(NUM_REQ - 1)) ? '0 : w_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and output registers; reset aborts any transaction without a pulse
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            w_q <= '0;
            rr_q <= '0;
            wd_q <= '0;
            gnt_q <= '0;
            done_q <= '0;
            to_q <= '0;
            start_q <= 1'b0;
            rd_q <= '0;
            sccb_q <= 1'b0;
            mode_q <= '0;
            sa_q <= '0;
            ra_q <= '0;
            bl_q <= '0;
            tx_q <= '0;
        end else begin
            state_q <= state_d;
            w_q <= w_d;
            rr_q <= rr_d;
            wd_q <= wd_d;
            gnt_q <= gnt_d;
            done_q <= done_d;
            to_q <= to_d;
            start_q <= start_d;
            rd_q <= rd_d;
            sccb_q <= sccb_d;
            mode_q <= mode_d;
            sa_q <= sa_d;
            ra_q <= ra_d;
            bl_q <= bl_d;
            tx_q <= tx_d;
        end
    end
endmodule

// File: tb/tb_sccb_bus_arbiter.sv
// tb_sccb_bus_arbiter: randomized scoreboard bench for sccb_bus_arbiter with a behavioural master model
module tb_sccb_bus_arbiter;
    localparam int N = 3;
    localparam int TO = 100;
    localparam logic [2:0] MASK = 3'b101;

    logic clk = 0, rst = 1;
    logic [2:0] req = 0;
    logic [5:0] req_mode = 0, req_bl = 0;
    logic [20:0] req_sa = 0;
    logic [23:0] req_ra = 0;
    logic [95:0] req_tx = 0;
    logic [2:0] gnt, done, tmo;
    logic [31:0] rd, m_tx, m_rx = 0;
    logic busy, m_start, m_ready = 1, m_done = 0, m_sccb;
    logic [1:0] m_mode, m_bl;
    logic [6:0] m_sa;
    logic [7:0] m_ra;

    always #5 clk = ~clk;

    sccb_bus_arbiter #(.NUM_REQ(N), .SCCB_MASK(MASK), .TIMEOUT_CYCLES(24'(TO))) dut (
        .clk_i(clk), .reset_i(rst), .req_i(req), .req_mode_i(req_mode),
        .req_slave_addr_i(req_sa), .req_reg_addr_i(req_ra), .req_burst_len_i(req_bl),
        .req_tx_data_i(req_tx), .gnt_o(gnt), .req_done_o(done), .req_timeout_o(tmo),
        .rd_data_o(rd), .busy_o(busy), .m_start_o(m_start), .m_ready_i(m_ready),
        .m_done_i(m_done), .m_sccb_en_o(m_sccb), .m_mode_o(m_mode), .m_slave_addr_o(m_sa),
        .m_reg_addr_o(m_ra), .m_burst_len_o(m_bl), .m_tx_data_o(m_tx), .m_rx_data_i(m_rx)
    );

    typedef struct {int client; logic [51:0] cmd;} txn_t;
    typedef struct {bit is_done; int at; logic [31:0] rx;} out_t;
    txn_t txn_q[$];
    out_t out_q[$];
    int total = 0, bad = 0, cyc = 0, mrr = 0, cur = 0;
    int fixed_k = -2;
    bit fixed_rx_en = 0, drop_en = 0;
    logic [31:0] fixed_rx = 0, exp_rd = 0;
    logic [2:0] sccb_mask = MASK;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic finish_up();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    function automatic logic [51:0] cmd_of(input int i);
        return {sccb_mask[i], req_mode[2*i +: 2], req_sa[7*i +: 7], req_ra[8*i +: 8],
                req_bl[2*i +: 2], req_tx[32*i +: 32]};
    endfunction

    task automatic scramble(input int i);
        req_mode[2*i +: 2] = 2'($urandom);
        req_sa[7*i +: 7] = 7'($urandom);
        req_ra[8*i +: 8] = 8'($urandom);
        req_bl[2*i +: 2] = 2'($urandom);
        req_tx[32*i +: 32] = $urandom;
    endtask

    // model: every requester of the round is served once, in cyclic order from the pointer
    task automatic start_round(input logic [2:0] mask, input bit rnd);
        logic [2:0] left;
        int c;
        left = mask;
        for (int i = 0; i < N; i++) if (rnd && mask[i]) scramble(i);
        while (left != 0) begin
            for (int k = 0; k < N; k++) begin
                c = (mrr + k) % N;
                if (left[c]) begin
                    txn_q.push_back('{c, cmd_of(c)});
                    left[c] = 1'b0;
                    mrr = (c + 1) % N;
                    break;
                end
            end
        end
        req = mask;
    endtask

    task automatic wait_round();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            for (int i = 0; i < N; i++) begin
                if (done[i] || tmo[i]) begin
                    req[i] = 1'b0;
                    scramble(i);
                end
                if (m_start && gnt[i] && drop_en && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b0;
                    scramble(i);
                end
            end
            if (req == 0 && txn_q.size() == 0 && out_q.size() == 0) begin
                @(posedge clk); #2;
                chk("idle_busy", 64'(busy), 0);
                chk("idle_gnt", 64'(gnt), 0);
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL round_budget: round still open after 3000 cycles, req=%0b", req);
        finish_up();
    endtask

    function automatic int pick();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 20);
        if (r < 8) return TO - 1;
        if (r == 8) return TO;
        return -1;
    endfunction

    // master model: k = cycles after start until done (-1 never, -3 hang until reset)
    initial begin : master
        int k, cnt, endc;
        bit active;
        logic [31:0] rx;
        active = 0;
        k = 0;
        cnt = 0;
        endc = 0;
        rx = 0;
        forever begin
            @(posedge clk); #1;
            m_done = 0;
            m_rx = $urandom;
            if (rst) begin
                active = 0;
                m_ready = 1;
            end else begin
                if (!active && m_start) begin
                    active = 1;
                    m_ready = 0;
                    cnt = 0;
                    k = (fixed_k != -2) ? fixed_k : pick();
                    rx = fixed_rx_en ? fixed_rx : $urandom;
                    if (k >= 0 && k < TO) out_q.push_back('{1'b1, cyc + k + 1, rx});
                    else if (k != -3) out_q.push_back('{1'b0, cyc + TO, 32'h0});
                    endc = (k == -3) ? (1 << 30) : (k < 0 ? TO + 5 : k);
                end
                if (active) begin
                    if (cnt == k) begin
                        m_done = 1;
                        m_rx = rx;
                    end
                    if (cnt == endc) begin
                        active = 0;
                        m_ready = 1;
                    end
                    cnt++;
                end
            end
        end
    end

    // monitor: pops expectations whenever the DUT starts a transaction or pulses a result
    initial begin : monitor
        logic [2:0] pg;
        int gcyc;
        txn_t t;
        out_t o;
        pg = 0;
        gcyc = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                pg = 0;
                exp_rd = 0;
            end else begin
                chk("gnt_onehot", 64'($onehot0(gnt)), 1);
                chk("done_onehot", 64'($onehot0(done)), 1);
                chk("tmo_onehot", 64'($onehot0(tmo)), 1);
                if (gnt != 0 && pg == 0) gcyc = cyc;
                if (m_start) begin
                    if (txn_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_start: got m_start with no pending request at cycle %0d", cyc);
                    end else begin
                        t = txn_q.pop_front();
                        cur = t.client;
                        chk("start_gnt", 64'(gnt), 64'(3'b1 << t.client));
                        chk("start_cmd", 64'({m_sccb, m_mode, m_sa, m_ra, m_bl, m_tx}), 64'(t.cmd));
                        chk("start_busy", 64'(busy), 1);
                        chk("start_latency", 64'(cyc - gcyc >= 2), 1);
                    end
                end
                if (done != 0 || tmo != 0) begin
                    if (out_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pulse: got done=%0b timeout=%0b at cycle %0d", done, tmo, cyc);
                    end else begin
                        o = out_q.pop_front();
                        chk("pulse_kind", 64'({done, tmo}),
                            o.is_done ? 64'({3'b1 << cur, 3'b0}) : 64'({3'b0, 3'b1 << cur}));
                        chk("pulse_cycle", 64'(cyc), 64'(o.at));
                        chk("pulse_gnt", 64'(gnt), 0);
                        if (o.is_done) exp_rd = o.rx;
                    end
                end
                chk("rd_data", 64'(rd), 64'(exp_rd));
                pg = gnt;
            end
        end
    end

    initial begin
        #600000;
        total++;
        bad++;
        $display("FAIL sim_timeout: bench exceeded its time limit");
        finish_up();
    end

    initial begin
        logic [2:0] m;
        rst = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_gnt", 64'(gnt), 0);
        chk("rst_pulses", 64'({done, tmo}), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_start", 64'(m_start), 0);
        chk("rst_rd", 64'(rd), 0);
        chk("rst_cmd", 64'({m_sccb, m_mode, m_sa, m_ra, m_bl, m_tx}), 0);
        rst = 0;
        mrr = 0;
        fixed_k = 5;
        start_round(3'b111, 1);
        wait_round();
        start_round(3'b111, 1);
        wait_round();
        fixed_k = 2;
        req_mode[1:0] = 2'b10;
        req_sa[6:0] = 7'h21;
        req_ra[7:0] = 8'h12;
        req_bl[1:0] = 2'b00;
        req_tx[31:0] = 32'h8000_0000;
        start_round(3'b001, 0);
        @(posedge clk); #2;
        chk("t1_gnt", 64'(gnt), 64'(3'b001));
        @(posedge clk); #2;
        chk("t1_no_early_start", 64'(m_start), 0);
        @(posedge clk); #2;
        chk("t1_start", 64'(m_start), 1);
        chk("t1_reg", 64'(m_ra), 64'h12);
        chk("t1_tx", 64'(m_tx), 64'h8000_0000);
        chk("t1_sccb", 64'(m_sccb), 1);
        wait_round();
        fixed_k = -1;
        start_round(3'b010, 1);
        wait_round();
        fixed_k = TO - 1;
        start_round(3'b100, 1);
        wait_round();
        fixed_k = 3;
        fixed_rx_en = 1;
        fixed_rx = 32'h7600_0000;
        scramble(2);
        req_mode[5:4] = 2'b01;
        start_round(3'b100, 0);
        wait_round();
        fixed_rx_en = 0;
        repeat (5) @(posedge clk);
        #2;
        chk("t5_rd_held", 64'(rd), 64'h7600_0000);
        fixed_k = -2;
        drop_en = 1;
        for (int r = 0; r < 40; r++) begin
            m = 3'($urandom_range(1, 7));
            start_round(m, 1);
            wait_round();
        end
        drop_en = 0;
        fixed_k = 1;
        start_round(3'b001, 1);
        wait_round();
        fixed_k = -3;
        start_round(3'b010, 1);
        for (int c = 0; c < 50 && txn_q.size() != 0; c++) begin
            @(posedge clk); #2;
        end
        chk("t6_started", 64'(txn_q.size()), 0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1;
        req = 0;
        @(posedge clk); #2;
        chk("t6_gnt", 64'(gnt), 0);
        chk("t6_busy", 64'(busy), 0);
        chk("t6_start", 64'(m_start), 0);
        chk("t6_pulses", 64'({done, tmo}), 0);
        rst = 0;
        mrr = 0;
        repeat (20) @(posedge clk);
        #2;
        chk("t6_idle", 64'(busy), 0);
        fixed_k = 4;
        start_round(3'b111, 1);
        wait_round();
        finish_up();
    end
endmodule
